tlb: RTL

- TLB array that responds to the write-back stage's TLB requests: TLBWI writes, TLBR reads and TLBP probes.
- Also serves the two translation lookup ports used by fetch (s0) and load/store (s1).
- Holds TLBNUM fully-associative MIPS32 entries. Each entry is one even/odd page pair.
- Writes commit at the clock edge. Lookups and reads are combinational. Probe results are registered, one cycle later.

---
 rtl/tlb_pkg.sv | 42 ++++
 rtl/tlb_match.sv | 33 +++
 rtl/tlb.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tlb_pkg.sv
// Shared TLB entry layout: field widths, bit positions and small field helpers.
package tlb_pkg;

  localparam int unsigned TLB_ENTRY_WD = 78;
  localparam int unsigned VPN2_WD      = 19;
  localparam int unsigned PFN_WD       = 20;
  localparam int unsigned ASID_WD      = 8;

  // Bit positions inside a packed entry
  localparam int unsigned VPN2_LSB = 59;
  localparam int unsigned ASID_LSB = 51;
  localparam int unsigned G_BIT    = 50;
  localparam int unsigned PFN0_LSB = 30;
  localparam int unsigned C0_LSB   = 27;
  localparam int unsigned D0_BIT   = 26;
  localparam int unsigned V0_BIT   = 25;
  localparam int unsigned PFN1_LSB = 5;
  localparam int unsigned C1_LSB   = 2;
  localparam int unsigned D1_BIT   = 1;
  localparam int unsigned V1_BIT   = 0;

  // Match tag = {vpn2, asid, g}, the top 28 bits of an entry
  localparam int unsigned TAG_WD = VPN2_WD + ASID_WD + 1;

  // One page half of an entry; field order mirrors the entry packing
  typedef struct packed {
    logic [PFN_WD-1:0] pfn;
    logic [2:0]        c;
    logic              d;
    logic              v;
  } tlb_page_t;

  function automatic logic [TAG_WD-1:0] tag_of(input logic [TLB_ENTRY_WD-1:0] e);
    return e[TLB_ENTRY_WD-1:G_BIT];
  endfunction

  // Even page lives in [49:25], odd page in [24:0]
  function automatic tlb_page_t page_sel(input logic [TLB_ENTRY_WD-1:0] e, input logic odd);
    return odd ? tlb_page_t'(e[V0_BIT-1:V1_BIT]) : tlb_page_t'(e[G_BIT-1:V0_BIT]);
  endfunction

endpackage

// File: rtl/tlb_match.sv
// Fully-associative tag compare with lowest-index priority encoding.
module tlb_match
  import tlb_pkg::*;
#(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned IDXW   = $clog2(TLBNUM)
) (
  input  logic [VPN2_WD-1:0]       vpn2,
  input  logic [ASID_WD-1:0]       asid,
  input  logic [TLBNUM*TAG_WD-1:0] tags,
  output logic [TLBNUM-1:0]        match,
  output logic                     found,
  output logic [IDXW-1:0]          index
);

  logic [TAG_WD-1:0] tag;

  // Per-entry compare, then scan downwards so the lowest hit index wins
  always_comb begin
    match = '0;
    tag   = '0;
    for (int i = 0; i < int'(TLBNUM); i++) begin
      tag      = tags[i*TAG_WD +: TAG_WD];
      match[i] = (tag[TAG_WD-1 -: VPN2_WD] == vpn2) && (tag[0] || (tag[ASID_WD:1] == asid));
    end
    found = |match;
    index = '0;
    for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
      if (match[i]) index = IDXW'(i);
    end
  end

endmodule

// File: rtl/tlb.sv
// MIPS32 TLB: TLBWI write, TLBR read, registered TLBP probe and two lookup ports.
module tlb
  import tlb_pkg::*;
#(
  parameter  int unsigned TLBNUM = 16,
  localparam int unsigned IDXW   = $clog2(TLBNUM)
) (
  input  logic                    clk,
  input  logic                    reset,
  // fetch lookup
  input  logic [VPN2_WD-1:0]      s0_vpn2,
  input  logic                    s0_odd_page,
  input  logic [ASID_WD-1:0]      s0_asid,
  output logic                    s0_found,
  output logic [IDXW-1:0]         s0_index,
  output logic [PFN_WD-1:0]       s0_pfn,
  output logic [2:0]              s0_c,
  output logic                    s0_d,
  output logic                    s0_v,
  // load/store lookup
  input  logic [VPN2_WD-1:0]      s1_vpn2,
  input  logic                    s1_odd_page,
  input  logic [ASID_WD-1:0]      s1_asid,
  output logic                    s1_found,
  output logic [IDXW-1:0]         s1_index,
  output logic [PFN_WD-1:0]       s1_pfn,
  output logic [2:0]              s1_c,
  output logic                    s1_d,
  output logic                    s1_v,
  // TLBWI
  input  logic                    w_en,
  input  logic [IDXW-1:0]         w_index,
  input  logic [TLB_ENTRY_WD-1:0] w_entry,
  // TLBR
  input  logic [IDXW-1:0]         r_index,
  output logic [TLB_ENTRY_WD-1:0] r_entry,
  // TLBP
  input  logic                    p_req,
  input  logic [VPN2_WD-1:0]      p_vpn2,
  input  logic [ASID_WD-1:0]      p_asid,
  output logic                    p_valid,
  output logic                    p_found,
  output logic [IDXW-1:0]         p_index
);

  logic [TLB_ENTRY_WD-1:0]  entry_q [TLBNUM];
  logic [TLBNUM*TAG_WD-1:0] tags;

  logic [TLBNUM-1:0] s0_match, s1_match, pm_match;
  logic              s0_hit, s1_hit, pm_found;
  logic [IDXW-1:0]   s0_idx, s1_idx, pm_index;
  tlb_page_t         s0_pg, s1_pg;

  // Entry storage: synchronous clear, single write port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(TLBNUM); i++) entry_q[i] <= '0;
    end else if (w_en) begin
      entry_q[w_index] <= w_entry;
    end
  end

  // Flatten only the tag fields for the matchers
  always_comb begin
    tags = '0;
    for (int i = 0; i < int'(TLBNUM); i++) tags[i*TAG_WD +: TAG_WD] = tag_of(entry_q[i]);
  end

  tlb_match #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_match_s0 (
    .vpn2 (s0_vpn2),
    .asid (s0_asid),
    .tags (tags),
    .match(s0_match),
    .found(s0_hit),
    .index(s0_idx)
  );

  tlb_match #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_match_s1 (
    .vpn2 (s1_vpn2),
    .asid (s1_asid),
    .tags (tags),
    .match(s1_match),
    .found(s1_hit),
    .index(s1_idx)
  );

  tlb_match #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_match_p (
    .vpn2 (p_vpn2),
    .asid (p_asid),
    .tags (tags),
    .match(pm_match),
    .found(pm_found),
    .index(pm_index)
  );

  // One-hot mux on the lowest set match bit; an empty vector yields an all-zero page
  function automatic tlb_page_t pick_page(input logic [TLBNUM-1:0] m, input logic odd);
    logic [TLBNUM-1:0] sel;
    tlb_page_t         pg;
    sel = m & (-m);
    pg  = '0;
    for (int i = 0; i < int'(TLBNUM); i++) begin
      if (sel[i]) pg = pg | page_sel(entry_q[i], odd);
    end
    return pg;
  endfunction

  // Combinational lookup ports and TLBR read
  always_comb begin
    s0_pg    = pick_page(s0_match, s0_odd_page);
    s1_pg    = pick_page(s1_match, s1_odd_page);
    s0_found = s0_hit;
    s0_index = s0_idx;
    s0_pfn   = s0_pg.pfn;
    s0_c     = s0_pg.c;
    s0_d     = s0_pg.d;
    s0_v     = s0_pg.v;
    s1_found = s1_hit;
    s1_index = s1_idx;
    s1_pfn   = s1_pg.pfn;
    s1_c     = s1_pg.c;
    s1_d     = s1_pg.d;
    s1_v     = s1_pg.v;
    r_entry  = entry_q[r_index];
  end

  // Probe pipeline: result sampled against pre-write contents; held when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_found <= 1'b0;
      p_index <= '0;
    end else if (p_req) begin
      p_valid <= 1'b1;
      p_found <= pm_found;
      p_index <= pm_index;
    end else begin
      p_valid <= 1'b0;
    end
  end

  // Priority encoder must agree with the raw match vector
  always_ff @(posedge clk) begin
    if (!reset) assert (pm_found == (|pm_match));
  end

endmodule
